// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: round-robin sharing of the UART MMIO port between two masters (optional UART_ARB_TIMEOUT_EN abort).
// Latency: request reaches s_ bus 1 cycle after it is seen; m_response 1 cycle after s_response; grant frees 1 cycle later.
// Backpressure: masters hold their request level until m_response; the grant is held until the UART responds (or times out).
module uart_bus_arbiter #(
    parameter int          RESET_PRIORITY = 0,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  m_read,
    input  logic [1:0]  m_write,
    input  logic [63:0] m_address,
    input  logic [63:0] m_write_data,
    output logic [31:0] m_read_data,
    output logic [1:0]  m_response,
    output logic [1:0]  grant,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_address,
    output logic [31:0] s_write_data,
    input  logic [31:0] s_read_data,
    input  logic        s_response
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic        timeout_err
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t      state, state_d;
    logic        last_grant, last_grant_d;
    logic [1:0]  req;
    logic        pick;
    logic        timeout_hit;
    logic [1:0]  grant_d, m_response_d;
    logic        s_read_d, s_write_d;
    logic [31:0] s_address_d, s_write_data_d, m_read_data_d;

    assign req  = m_read | m_write;
    assign pick = (req == 2'b11) ? ~last_grant : req[1];

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] wait_cnt;
    logic        timeout_err_d;

    assign timeout_hit = (state == BUSY) && (wait_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if (state == BUSY) begin
            wait_cnt <= wait_cnt + 32'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            last_grant   <= (RESET_PRIORITY == 0) ? 1'b1 : 1'b0;
            grant        <= '0;
            m_response   <= '0;
            s_read       <= 1'b0;
            s_write      <= 1'b0;
            s_address    <= '0;
            s_write_data <= '0;
            m_read_data  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err  <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            last_grant   <= last_grant_d;
            grant        <= grant_d;
            m_response   <= m_response_d;
            s_read       <= s_read_d;
            s_write      <= s_write_d;
            s_address    <= s_address_d;
            s_write_data <= s_write_data_d;
            m_read_data  <= m_read_data_d;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err  <= timeout_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (|req) state_d = BUSY;
            BUSY:    if (s_response || timeout_hit) state_d = RELEASE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_grant_d   = last_grant;
        grant_d        = grant;
        m_response_d   = '0;
        s_read_d       = s_read;
        s_write_d      = s_write;
        s_address_d    = s_address;
        s_write_data_d = s_write_data;
        m_read_data_d  = m_read_data;
`ifdef UART_ARB_TIMEOUT_EN
        timeout_err_d  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_d        = pick ? 2'b10 : 2'b01;
                    last_grant_d   = pick;
                    s_address_d    = pick ? m_address[63:32]    : m_address[31:0];
                    s_write_data_d = pick ? m_write_data[63:32] : m_write_data[31:0];
                    // write wins when a master raises both strobes
                    s_write_d      = m_write[pick];
                    s_read_d       = m_read[pick] & ~m_write[pick];
                end
            end
            BUSY: begin
                if (s_response) begin
                    m_read_data_d = s_read_data;
                    m_response_d  = grant;
                    s_read_d      = 1'b0;
                    s_write_d     = 1'b0;
                end else if (timeout_hit) begin
                    m_read_data_d = ERR_DATA;
                    m_response_d  = grant;
                    s_read_d      = 1'b0;
                    s_write_d     = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
                    timeout_err_d = 1'b1;
`endif
                end
            end
            default: grant_d = '0;
        endcase
    end

endmodule

// File: doc/uart_bus_arbiter.md
Name: uart_bus_arbiter

Overview:
Two-requester arbiter that shares the single read/write/response MMIO port of the UART peripheral between master 0 (CPU data port) and master 1 (debug/boot loader). Round-robin grant, held until the UART returns its one-cycle response. One cycle of release gap keeps the UART from re-triggering out of its FINISH state. All outputs are registered.

Parameters:
RESET_PRIORITY, 0, master that wins the first simultaneous request after reset (0 or 1)
TIMEOUT_CYCLES, 1024, cycles to wait for s_response before abort (used only with UART_ARB_TIMEOUT_EN)
ERR_DATA, 32'hFFFFFFFF, m_read_data value returned on timeout abort

Ports:
clk  in  1  system clock; all logic on rising edge
resetn  in  1  reset; asynchronous, active-low
m_read  in  2  per-master read request, bit i = master i, level held until m_response[i]
m_write  in  2  per-master write request, same rules as m_read
m_address  in  64  master i address at bits [32i+31:32i]
m_write_data  in  64  master i write data at bits [32i+31:32i]
m_read_data  out  32  shared read data, valid in the cycle m_response[i]=1
m_response  out  2  one-cycle completion pulse to the granted master
grant  out  2  one-hot current owner, 00 when idle
s_read  out  1  to UART read
s_write  out  1  to UART write
s_address  out  32  to UART address
s_write_data  out  32  to UART write_data
s_read_data  in  32  from UART read_data
s_response  in  1  from UART response, one-cycle pulse
timeout_err  out  1  one-cycle abort pulse; port exists only with UART_ARB_TIMEOUT_EN

Behaviour:
- Reset (resetn=0, async, any state): state=IDLE; grant, m_response, s_read, s_write, timeout_err = 0; s_address, s_write_data, m_read_data = 0; last_grant = ~RESET_PRIORITY, so RESET_PRIORITY wins first.
- req[i] = m_read[i] | m_write[i]. If both bits are set for one master, write wins and is forwarded alone.
- IDLE: if no req, stay. If one req, grant it. If both req, grant the master != last_grant.
- On grant edge: grant<=onehot(i), last_grant<=i, s_address/s_write_data latched from master i, s_write or s_read <=1, state->BUSY. The request appears on the s_ bus the cycle after it is first seen.
- BUSY: s_read/s_write held high, and address/data held stable, until s_response=1. Master-side changes are ignored while BUSY.
- On s_response edge: m_read_data<=s_read_data (writes also pass s_read_data through; masters ignore it), m_response[i]<=1 for exactly one cycle, s_read/s_write<=0, state->RELEASE.
- RELEASE: one cycle; grant<=0, m_response<=0; ->IDLE. Masters must drop their request in the cycle m_response is high. IDLE re-samples two cycles after s_response, aligned with the UART returning to IDLE.
- Request dropped by a master while BUSY: transaction still completes and the response still pulses.
- Minimum back-to-back throughput: one transaction per (UART latency + 3) cycles. Master i is never granted twice in a row while the other master is requesting.
- s_response while IDLE/RELEASE: ignored, no m_response.

Optional Feature:
UART_ARB_TIMEOUT_EN. When defined, a 32-bit wait counter clears on grant and increments each BUSY cycle. When it reaches TIMEOUT_CYCLES-1 with no s_response: m_read_data<=ERR_DATA, m_response[i]<=1, timeout_err<=1 (one cycle each), s_read/s_write<=0, ->RELEASE. If s_response and the timeout coincide, the response wins and timeout_err stays 0. When undefined, there is no counter and no timeout_err port, and BUSY waits indefinitely.

Test Plan:
- Reset then m_read=01, addr 0x0, UART returns 0x000000A5 after 6 cycles -> s_read high cycles 1..6, m_response=01 one cycle with m_read_data=0xA5, grant=00 two cycles after s_response.
- m_write=11 same cycle (RESET_PRIORITY=0), data 0x11/0x22 -> master0 served first with s_write_data=0x11, then master1 with 0x22; never both granted.
- Master0 requests continuously while master1 requests -> grants alternate 0,1,0,1 across 4 transactions.
- m_read[0] and m_write[0] both 1 -> only s_write asserted, s_read stays 0.
- resetn pulsed low mid-BUSY -> s_read, s_write, grant, m_response drop to 0 immediately, without waiting for a clock edge; after release the next request is granted normally.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, UART never responds -> m_response and timeout_err pulse on BUSY cycle 16, m_read_data=0xFFFFFFFF, s_read low afterwards.
